// File: rtl/lut_mux_eval.sv
// Reprogrammable truth-table function generator: {sel,res} indexes a LUT loaded beat-wise into a
// shadow register and swapped in atomically. Optional table parity check: define LUT_PARITY_CHECK_EN.
module lut_mux_eval #(
   parameter int SEL_W = 3,
   parameter int RES_W = 2,
   parameter int CFG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_start,
   input  logic             cfg_valid,
   input  logic [CFG_W-1:0] cfg_data,
   input  logic             cfg_parity,
   output logic             cfg_ready,
   output logic             cfg_done,
   output logic             cfg_err,
   input  logic             in_valid,
   input  logic [SEL_W-1:0] sel,
   input  logic [RES_W-1:0] res,
   output logic             out_valid,
   output logic             y,
   output logic             miss
);

   localparam int IDX_W   = SEL_W + RES_W;
   localparam int TT_BITS = 1 << IDX_W;
   localparam int BEATS   = TT_BITS / CFG_W;
   localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic {
      ST_IDLE,
      ST_LOAD
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [TT_BITS-1:0]   shadow_q, shadow_d;
   logic [TT_BITS-1:0]   active_q, active_d;
   logic                 tbl_valid_q, tbl_valid_d;
   logic                 cfg_done_q, cfg_done_d;
   logic                 cfg_err_q, cfg_err_d;
   logic                 out_valid_q, out_valid_d;
   logic                 y_q, y_d;
   logic                 miss_q, miss_d;

   logic                 beat_acc;
   logic                 last_beat;
   logic                 parity_ok;
   logic [TT_BITS-1:0]   candidate;
   logic [IDX_W-1:0]     idx;

   // A cfg_start in LOAD wins over a coincident beat, so that beat is never accepted.
   assign beat_acc  = (state_q == ST_LOAD) && cfg_valid && !cfg_start;
   assign last_beat = beat_acc && (cnt_q == CNT_W'(BEATS - 1));
   assign idx       = {sel, res};

   // Shadow contents with the current beat merged into its slot.
   generate
      for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
         assign candidate[gi*CFG_W +: CFG_W] =
            (beat_acc && (cnt_q == CNT_W'(gi))) ? cfg_data : shadow_q[gi*CFG_W +: CFG_W];
      end
   endgenerate

`ifdef LUT_PARITY_CHECK_EN
   assign parity_ok = ((^candidate) == cfg_parity);
`else
   logic unused_parity;
   assign unused_parity = cfg_parity;
   assign parity_ok     = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shadow_d    = shadow_q;
      active_d    = active_q;
      tbl_valid_d = tbl_valid_q;
      cfg_done_d  = 1'b0;
      cfg_err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end
         end
         ST_LOAD: begin
            if (cfg_start) begin
               cnt_d = '0;
            end else if (beat_acc) begin
               shadow_d = candidate;
               if (last_beat) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  if (parity_ok) begin
                     active_d    = candidate;
                     tbl_valid_d = 1'b1;
                     cfg_done_d  = 1'b1;
                  end else begin
                     cfg_err_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Evaluation reads active_q, so a request alongside the final beat still sees the old table.
   always_comb begin
      out_valid_d = in_valid && tbl_valid_q;
      miss_d      = in_valid && !tbl_valid_q;
      y_d         = y_q;
      if (in_valid && tbl_valid_q) begin
         y_d = active_q[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shadow_q    <= '0;
         active_q    <= '0;
         tbl_valid_q <= 1'b0;
         cfg_done_q  <= 1'b0;
         cfg_err_q   <= 1'b0;
         out_valid_q <= 1'b0;
         y_q         <= 1'b0;
         miss_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shadow_q    <= shadow_d;
         active_q    <= active_d;
         tbl_valid_q <= tbl_valid_d;
         cfg_done_q  <= cfg_done_d;
         cfg_err_q   <= cfg_err_d;
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         miss_q      <= miss_d;
      end
   end

   assign cfg_ready = (state_q == ST_LOAD);
   assign cfg_done  = cfg_done_q;
`ifdef LUT_PARITY_CHECK_EN
   assign cfg_err   = cfg_err_q;
`else
   logic unused_err;
   assign unused_err = cfg_err_q;
   assign cfg_err    = 1'b0;
`endif
   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign miss      = miss_q;

endmodule

// File: tb/tb_lut_mux_eval.sv
// Bench for lut_mux_eval: directed load/evaluate scenarios plus random loads and requests,
// checked against a table-level model (a 32-bit truth table value and a valid flag).
module tb_lut_mux_eval;

   localparam int SEL_W = 3;
   localparam int RES_W = 2;
   localparam int CFG_W = 8;
   localparam int IDX_W = SEL_W + RES_W;
   localparam int BEATS = (1 << IDX_W) / CFG_W;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             cfg_start = 1'b0;
   logic             cfg_valid = 1'b0;
   logic [CFG_W-1:0] cfg_data = '0;
   logic             cfg_parity = 1'b0;
   logic             cfg_ready, cfg_done, cfg_err;
   logic             in_valid = 1'b0;
   logic [SEL_W-1:0] sel = '0;
   logic [RES_W-1:0] res = '0;
   logic             out_valid, y, miss;

   int checks = 0;
   int failures = 0;

   logic [31:0] ref_tbl = '0;
   logic        ref_valid = 1'b0;
   logic        ref_y = 1'b0;

   lut_mux_eval #(.SEL_W(SEL_W), .RES_W(RES_W), .CFG_W(CFG_W)) dut (
      .clk(clk), .rst(rst),
      .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_parity(cfg_parity),
      .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_err(cfg_err),
      .in_valid(in_valid), .sel(sel), .res(res),
      .out_valid(out_valid), .y(y), .miss(miss)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one request and compares against the model; leaves in_valid asserted.
   task automatic eval_req(input int idx, input string tag);
      in_valid = 1'b1;
      sel = idx[IDX_W-1:RES_W];
      res = idx[RES_W-1:0];
      step();
      if (ref_valid) ref_y = ref_tbl[idx];
      checks++;
      if (out_valid !== ref_valid) begin
         failures++;
         $display("FAIL %s out_valid idx=%0d got %b expected %b", tag, idx, out_valid, ref_valid);
      end
      checks++;
      if (y !== ref_y) begin
         failures++;
         $display("FAIL %s y idx=%0d got %b expected %b", tag, idx, y, ref_y);
      end
      checks++;
      if (miss !== !ref_valid) begin
         failures++;
         $display("FAIL %s miss idx=%0d got %b expected %b", tag, idx, miss, !ref_valid);
      end
      $display("eval %s idx=%0d y=%b out_valid=%b miss=%b", tag, idx, y, out_valid, miss);
   endtask

   task automatic load_table(input logic [31:0] t, input logic par, input string tag);
      bit ok;
`ifdef LUT_PARITY_CHECK_EN
      ok = (($countones(t) % 2) == int'(par));
`else
      ok = 1'b1;
`endif
      in_valid  = 1'b0;
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      checks++;
      if (cfg_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s ready_in_load got %b expected 1", tag, cfg_ready);
      end
      for (int k = 0; k < BEATS; k++) begin
         cfg_valid  = 1'b1;
         cfg_data   = t[k*CFG_W +: CFG_W];
         cfg_parity = par;
         step();
      end
      cfg_valid = 1'b0;
      checks++;
      if (cfg_done !== ok || cfg_err !== !ok) begin
         failures++;
         $display("FAIL %s done/err got %b/%b expected %b/%b", tag, cfg_done, cfg_err, ok, !ok);
      end
      checks++;
      if (cfg_ready !== 1'b0) begin
         failures++;
         $display("FAIL %s ready_after_load got %b expected 0", tag, cfg_ready);
      end
      if (ok) begin
         ref_tbl   = t;
         ref_valid = 1'b1;
      end
      step();
      checks++;
      if (cfg_done !== 1'b0 || cfg_err !== 1'b0) begin
         failures++;
         $display("FAIL %s pulse_width done/err got %b/%b expected 0/0", tag, cfg_done, cfg_err);
      end
      $display("load %s table=%08h parity=%b accepted=%b", tag, t, par, ok);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      checks++;
      if ({cfg_ready, cfg_done, cfg_err, out_valid, y, miss} !== 6'b0) begin
         failures++;
         $display("FAIL reset_outputs got %b expected 000000",
                  {cfg_ready, cfg_done, cfg_err, out_valid, y, miss});
      end
      ref_valid = 1'b0;
      ref_y     = 1'b0;
      eval_req(0, "reset_miss");
      in_valid = 1'b0;
      checks++;
      if (cfg_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready got %b expected 0", cfg_ready);
      end
   endtask

   task automatic test_load_eval();
      int idxs [4] = '{1, 8, 12, 31};
      logic exps [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      load_table(32'hA5C30F96, 1'b0, "basic");
      for (int i = 0; i < 4; i++) begin
         eval_req(idxs[i], "basic");
         in_valid = 1'b0;
         checks++;
         if (y !== exps[i] || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_const idx=%0d got y=%b ov=%b expected y=%b ov=1",
                     idxs[i], y, out_valid, exps[i]);
         end
         step();
         checks++;
         if (out_valid !== 1'b0 || y !== exps[i]) begin
            failures++;
            $display("FAIL idle_hold idx=%0d got ov=%b y=%b expected ov=0 y=%b",
                     idxs[i], out_valid, y, exps[i]);
         end
      end
   endtask

   task automatic test_reload_stream();
      in_valid  = 1'b1;
      sel       = 3'b011;
      res       = 2'b00;
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      for (int k = 0; k <= BEATS; k++) begin
         checks++;
         if (out_valid !== 1'b1 || y !== 1'b0) begin
            failures++;
            $display("FAIL stream_old cycle=%0d got ov=%b y=%b expected ov=1 y=0", k, out_valid, y);
         end
         if (k == BEATS) break;
         cfg_valid  = 1'b1;
         cfg_data   = 8'hFF;
         cfg_parity = 1'b0;
         step();
      end
      cfg_valid = 1'b0;
      checks++;
      if (cfg_done !== 1'b1) begin
         failures++;
         $display("FAIL stream_done got %b expected 1", cfg_done);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || y !== 1'b1) begin
         failures++;
         $display("FAIL stream_new got ov=%b y=%b expected ov=1 y=1", out_valid, y);
      end
      ref_tbl   = 32'hFFFFFFFF;
      ref_valid = 1'b1;
      ref_y     = 1'b1;
      $display("load stream table=ffffffff swapped under traffic");
   endtask

   task automatic test_abort();
      logic [7:0] beats [4] = '{8'h01, 8'h00, 8'h00, 8'h00};
      int done_cnt = 0;
      in_valid  = 1'b0;
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      cfg_valid = 1'b1;
      cfg_data  = 8'h12;
      step();
      done_cnt += int'(cfg_done);
      cfg_data  = 8'h34;
      step();
      done_cnt += int'(cfg_done);
      cfg_start = 1'b1;
      cfg_data  = 8'h56;
      step();
      done_cnt += int'(cfg_done);
      cfg_start = 1'b0;
      for (int k = 0; k < BEATS; k++) begin
         cfg_data   = beats[k];
         cfg_parity = 1'b1;
         step();
         done_cnt += int'(cfg_done);
      end
      cfg_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         done_cnt += int'(cfg_done);
      end
      checks++;
      if (done_cnt != 1) begin
         failures++;
         $display("FAIL abort_done_count got %0d expected 1", done_cnt);
      end
      ref_tbl   = 32'h00000001;
      ref_valid = 1'b1;
      $display("load abort then table=00000001 done_pulses=%0d", done_cnt);
      eval_req(0, "abort");
      checks++;
      if (y !== 1'b1) begin
         failures++;
         $display("FAIL abort_idx0 got %b expected 1", y);
      end
      eval_req(12, "abort");
      in_valid = 1'b0;
      checks++;
      if (y !== 1'b0) begin
         failures++;
         $display("FAIL abort_idx12 got %b expected 0", y);
      end
   endtask

   task automatic test_parity();
      load_table(32'hA5C30F96, 1'b1, "parity");
      eval_req(0, "parity");
      eval_req(4, "parity");
      in_valid = 1'b0;
`ifdef LUT_PARITY_CHECK_EN
      checks++;
      if (y !== 1'b0 || ref_tbl !== 32'h00000001) begin
         failures++;
         $display("FAIL parity_prior_table got y=%b expected 0", y);
      end
`endif
   endtask

   task automatic test_reset_mid_load();
      in_valid  = 1'b0;
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      cfg_valid = 1'b1;
      cfg_data  = 8'hAA;
      step();
      cfg_data  = 8'h55;
      step();
      cfg_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({cfg_ready, cfg_done, cfg_err, out_valid, y, miss} !== 6'b0) begin
         failures++;
         $display("FAIL midload_reset got %b expected 000000",
                  {cfg_ready, cfg_done, cfg_err, out_valid, y, miss});
      end
      ref_valid = 1'b0;
      ref_y     = 1'b0;
      eval_req(12, "midreset");
      in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int l = 0; l < 3; l++) begin
         load_table($urandom, 1'($urandom_range(0, 1)), "random");
         for (int c = 0; c < 24; c++) begin
            if ($urandom_range(0, 3) != 0) begin
               eval_req(int'($urandom_range(0, 31)), "b2b");
            end else begin
               in_valid = 1'b0;
               step();
               checks++;
               if (out_valid !== 1'b0 || miss !== 1'b0 || y !== ref_y) begin
                  failures++;
                  $display("FAIL b2b_idle got ov=%b miss=%b y=%b expected 0/0/%b",
                           out_valid, miss, y, ref_y);
               end
            end
         end
         in_valid = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_load_eval();
      test_reload_stream();
      test_abort();
      test_parity();
      test_reset_mid_load();
      test_back_to_back();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
